time_counter: RTL and testbench

Free-running BCD time-of-day counter that sits directly downstream of the manual time-setting stage. It divides CLK down to a 1 Hz tick and advances seconds, minutes and hours in either 24-hour or 12-hour (AM/PM) mode. It accepts a load of hour/minute from the setting stage and feeds its current time back to that stage's inHour/inMinute and to the display.

---
 rtl/time_counter.sv | 236 +++++++++++++++++++++++
 tb/tb_time_counter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// ============================================================================
// time_counter
// ----------------------------------------------------------------------------
// Free-running BCD time-of-day counter. A prescaler divides CLK down to a
// one-second tick that advances second, minute and hour in either 24-hour or
// 12-hour (AM/PM) format. The manual time-setting stage can load hour and
// minute. The current time is fed back to that stage and to the display.
//
// Parameters
//   TICKS_PER_SEC : CLK cycles per second (minimum 2)
//
// Ports
//   CLK        in   system clock, rising edge active
//   RST        in   asynchronous active-high reset
//   mode       in   0 = 24-hour, 1 = 12-hour
//   load       in   load inHour/inMinute this cycle (ignored when invalid)
//   inHour     in   [7:0] BCD hour from the setting stage
//   inMinute   in   [7:0] BCD minute from the setting stage
//   hour       out  [7:0] BCD hour (00-23 or 01-12)
//   minute     out  [7:0] BCD minute (00-59)
//   second     out  [7:0] BCD second (00-59)
//   pm         out  PM flag, held 0 in 24-hour mode
//   sec_pulse  out  one-cycle strobe when a new second becomes visible
//   min_pulse  out  one-cycle strobe when a carried minute becomes visible
// ============================================================================
module time_counter #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       mode,
    input  logic       load,
    input  logic [7:0] inHour,
    input  logic [7:0] inMinute,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic       pm,
    output logic       sec_pulse,
    output logic       min_pulse
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] TERMINAL = PW'(TICKS_PER_SEC - 1);

    // ------------------------------------------------------------------------
    // BCD helpers. All arithmetic is done per nibble so that the outputs can
    // never leave the BCD code space.
    // ------------------------------------------------------------------------

    // Increment a two-digit BCD value; the caller handles range wrap-around.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    // Subtract 12 from a BCD hour in 13..23.
    function automatic logic [7:0] bcd_sub12(input logic [7:0] v);
        if (v[3:0] >= 4'd2) begin
            return {v[7:4] - 4'd1, v[3:0] - 4'd2};
        end else begin
            return {v[7:4] - 4'd2, v[3:0] + 4'd8};
        end
    endfunction

    // Add 12 to a BCD hour in 01..11.
    function automatic logic [7:0] bcd_add12(input logic [7:0] v);
        if (v[3:0] >= 4'd8) begin
            return {v[7:4] + 4'd2, v[3:0] - 4'd8};
        end else begin
            return {v[7:4] + 4'd1, v[3:0] + 4'd2};
        end
    endfunction

    function automatic logic minute_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    // Hour range depends on the mode being loaded into, not the old mode.
    function automatic logic hour_ok(input logic [7:0] v, input logic twelve);
        logic digits_ok;
        digits_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
        if (!digits_ok) begin
            return 1'b0;
        end else if (twelve) begin
            return ((v[7:4] == 4'd0) && (v[3:0] != 4'd0)) ||
                   ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2));
        end else begin
            return (v[7:4] <= 4'd1) ||
                   ((v[7:4] == 4'd2) && (v[3:0] <= 4'd3));
        end
    endfunction

    // ------------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------------
    logic [PW-1:0] prescaler;
    logic          tick_pending;
    logic          mode_q;

    logic          tick;
    logic          load_ok;
    logic          convert;
    logic          advance;
    logic [PW-1:0] prescaler_next;

    logic [7:0]    second_next;
    logic          sec_carry;
    logic [7:0]    minute_next;
    logic          min_carry;
    logic [7:0]    hour_inc;
    logic          pm_inc;
    logic [7:0]    hour_conv;
    logic          pm_conv;

    // ------------------------------------------------------------------------
    // Cycle qualification. A valid load wins over everything; a mode change
    // wins over a tick, which is then deferred by one cycle via tick_pending.
    // An invalid load simply falls through as if load were low.
    // ------------------------------------------------------------------------
    always_comb begin
        tick           = (prescaler == TERMINAL);
        load_ok        = load && minute_ok(inMinute) && hour_ok(inHour, mode);
        convert        = !load_ok && (mode != mode_q);
        advance        = !load_ok && !convert && (tick || tick_pending);
        prescaler_next = tick ? '0 : prescaler + PW'(1);
    end

    // ------------------------------------------------------------------------
    // Time-of-day increment chain: second -> minute -> hour. The hour step
    // follows the registered mode, which equals the input mode whenever an
    // advance is allowed.
    // ------------------------------------------------------------------------
    always_comb begin
        sec_carry   = (second == 8'h59);
        second_next = sec_carry ? 8'h00 : bcd_inc(second);

        min_carry   = (minute == 8'h59);
        minute_next = min_carry ? 8'h00 : bcd_inc(minute);

        hour_inc = bcd_inc(hour);
        pm_inc   = pm;
        if (mode_q) begin
            if (hour == 8'h12) begin
                hour_inc = 8'h01;
            end else if (hour == 8'h11) begin
                pm_inc = ~pm;
            end
        end else if (hour == 8'h23) begin
            hour_inc = 8'h00;
        end
    end

    // ------------------------------------------------------------------------
    // Mode conversion between 24-hour and 12-hour representations. The
    // target format is the new input mode.
    // ------------------------------------------------------------------------
    always_comb begin
        hour_conv = hour;
        pm_conv   = 1'b0;
        if (mode) begin
            if (hour == 8'h00) begin
                hour_conv = 8'h12;
            end else if (hour == 8'h12) begin
                pm_conv   = 1'b1;
            end else if (hour > 8'h12) begin
                hour_conv = bcd_sub12(hour);
                pm_conv   = 1'b1;
            end
        end else begin
            if (pm) begin
                if (hour != 8'h12) begin
                    hour_conv = bcd_add12(hour);
                end
            end else if (hour == 8'h12) begin
                hour_conv = 8'h00;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers. mode_q simply tracks mode every cycle: loads and
    // conversions both adopt the new mode, and otherwise mode already equals
    // mode_q. The prescaler keeps running through conversions so a deferred
    // tick does not shift the one-second phase.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hour         <= 8'h00;
            minute       <= 8'h00;
            second       <= 8'h00;
            pm           <= 1'b0;
            sec_pulse    <= 1'b0;
            min_pulse    <= 1'b0;
            prescaler    <= '0;
            tick_pending <= 1'b0;
            mode_q       <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            min_pulse <= 1'b0;
            mode_q    <= mode;
            prescaler <= prescaler_next;

            if (load_ok) begin
                hour         <= inHour;
                minute       <= inMinute;
                second       <= 8'h00;
                prescaler    <= '0;
                tick_pending <= 1'b0;
                if (!mode) begin
                    pm <= 1'b0;
                end
            end else if (convert) begin
                hour         <= hour_conv;
                pm           <= pm_conv;
                tick_pending <= tick_pending | tick;
            end else if (advance) begin
                second       <= second_next;
                sec_pulse    <= 1'b1;
                tick_pending <= 1'b0;
                if (sec_carry) begin
                    minute    <= minute_next;
                    min_pulse <= 1'b1;
                    if (min_carry) begin
                        hour <= hour_inc;
                        pm   <= pm_inc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_time_counter.sv
// ============================================================================
// tb_time_counter
// ----------------------------------------------------------------------------
// Directed bench for time_counter with TICKS_PER_SEC = 4. Expected outputs
// are pushed onto a scoreboard queue as each step is driven and popped when
// the DUT output for that step is sampled, 1 ns after the clock edge.
// ============================================================================
module tb_time_counter;

    localparam int TPS = 4;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
        logic       pm;
        logic       sec_pulse;
        logic       min_pulse;
    } obs_t;

    logic       CLK;
    logic       RST;
    logic       mode;
    logic       load;
    logic [7:0] inHour;
    logic [7:0] inMinute;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
    logic       pm;
    logic       sec_pulse;
    logic       min_pulse;

    obs_t  exp_q[$];
    string tag_q[$];
    int    vectors;
    int    miscompares;

    // Reference time of day in plain integers.
    int mh;
    int mm;
    int ms;
    bit mpm;
    bit m12;

    time_counter #(.TICKS_PER_SEC(TPS)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .mode      (mode),
        .load      (load),
        .inHour    (inHour),
        .inMinute  (inMinute),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .pm        (pm),
        .sec_pulse (sec_pulse),
        .min_pulse (min_pulse)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] toBcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic waitCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic pushExp(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                           input logic p, input logic sp, input logic mp, input string tag);
        obs_t e;
        e = {h, m, s, p, sp, mp};
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic checkOutput();
        obs_t  expected;
        obs_t  observed;
        string tag;
        observed = {hour, minute, second, pm, sec_pulse, min_pulse};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h:%h:%h, required a queued entry",
                   hour, minute, second);
        end else begin
            expected = exp_q.pop_front();
            tag      = tag_q.pop_front();
            assert (observed === expected) else begin
                miscompares++;
                $error("FAIL %s: observed %h:%h:%h pm=%b sp=%b mp=%b, expected %h:%h:%h pm=%b sp=%b mp=%b",
                       tag, observed.hour, observed.minute, observed.second, observed.pm,
                       observed.sec_pulse, observed.min_pulse, expected.hour, expected.minute,
                       expected.second, expected.pm, expected.sec_pulse, expected.min_pulse);
            end
        end
    endtask

    // Queue an expectation, advance one clock, then compare.
    task automatic applyStimulus(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                 input logic p, input logic sp, input logic mp, input string tag);
        pushExp(h, m, s, p, sp, mp, tag);
        waitCycle();
        checkOutput();
    endtask

    task automatic modelTick(output bit carry);
        carry = 1'b0;
        ms++;
        if (ms == 60) begin
            ms    = 0;
            carry = 1'b1;
            mm++;
            if (mm == 60) begin
                mm = 0;
                if (!m12) begin
                    mh = (mh + 1) % 24;
                end else if (mh == 12) begin
                    mh = 1;
                end else begin
                    if (mh == 11) mpm = !mpm;
                    mh++;
                end
            end
        end
    endtask

    // One full second starting from prescaler phase 0: quiet cycles, then tick.
    task automatic runPeriod(input string tag);
        bit carry;
        for (int i = 1; i < TPS; i++) begin
            applyStimulus(toBcd(mh), toBcd(mm), toBcd(ms), mpm, 1'b0, 1'b0, {tag, "_idle"});
        end
        modelTick(carry);
        applyStimulus(toBcd(mh), toBcd(mm), toBcd(ms), mpm, 1'b1, carry, {tag, "_tick"});
    endtask

    task automatic setModel(input int h, input int m, input int s, input bit p, input bit twelve);
        mh  = h;
        mm  = m;
        ms  = s;
        mpm = p;
        m12 = twelve;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST         = 1'b0;
        mode        = 1'b0;
        load        = 1'b0;
        inHour      = 8'h00;
        inMinute    = 8'h00;
        setModel(0, 0, 0, 1'b0, 1'b0);

        // Asynchronous reset before any clock edge, then held across edges.
        #1 RST = 1'b1;
        #1;
        pushExp(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "reset_async");
        checkOutput();
        applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "reset_held");
        RST = 1'b0;

        // First ticks after reset release: second 01 at edge 4, 02 at edge 8.
        runPeriod("first_sec");
        runPeriod("second_sec");

        // 24h rollover 23:59:00 -> 00:00:00 after 60 ticks.
        load     = 1'b1;
        inHour   = 8'h23;
        inMinute = 8'h59;
        applyStimulus(8'h23, 8'h59, 8'h00, 1'b0, 1'b0, 1'b0, "load_2359");
        load = 1'b0;
        setModel(23, 59, 0, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) runPeriod("roll24");

        // 12h: 11:59 AM -> 12:00 PM, then 12:59 PM -> 01:00 PM.
        mode     = 1'b1;
        load     = 1'b1;
        inHour   = 8'h11;
        inMinute = 8'h59;
        applyStimulus(8'h11, 8'h59, 8'h00, 1'b0, 1'b0, 1'b0, "load_1159");
        load = 1'b0;
        setModel(11, 59, 0, 1'b0, 1'b1);
        for (int i = 0; i < 60; i++) runPeriod("roll11to12");
        load     = 1'b1;
        inHour   = 8'h12;
        inMinute = 8'h59;
        applyStimulus(8'h12, 8'h59, 8'h00, 1'b1, 1'b0, 1'b0, "load_1259");
        load = 1'b0;
        setModel(12, 59, 0, 1'b1, 1'b1);
        for (int i = 0; i < 60; i++) runPeriod("roll12to1");

        // Mode conversions from 15:00, then one landing on a tick cycle.
        mode     = 1'b0;
        load     = 1'b1;
        inHour   = 8'h15;
        inMinute = 8'h00;
        applyStimulus(8'h15, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "load_1500");
        load = 1'b0;
        mode = 1'b1;
        applyStimulus(8'h03, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, "conv_24to12");
        mode = 1'b0;
        applyStimulus(8'h15, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "conv_12to24");
        applyStimulus(8'h15, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "conv_quiet");
        mode = 1'b1;
        applyStimulus(8'h03, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, "conv_on_tick");
        applyStimulus(8'h03, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0, "deferred_tick");
        applyStimulus(8'h03, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, "phase_idle1");
        applyStimulus(8'h03, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, "phase_idle2");
        applyStimulus(8'h03, 8'h00, 8'h02, 1'b1, 1'b1, 1'b0, "phase_kept");
        setModel(3, 0, 2, 1'b1, 1'b1);

        // Invalid loads held for a full second are ignored; counting goes on.
        load     = 1'b1;
        inHour   = 8'h00;
        inMinute = 8'h30;
        runPeriod("bad_hour00_12h");
        inHour   = 8'h05;
        inMinute = 8'h60;
        runPeriod("bad_min60");
        load = 1'b0;

        mode     = 1'b0;
        load     = 1'b1;
        inHour   = 8'h10;
        inMinute = 8'h20;
        applyStimulus(8'h10, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, "load_1020");
        setModel(10, 20, 0, 1'b0, 1'b0);
        inHour   = 8'h24;
        inMinute = 8'h10;
        runPeriod("bad_hour24");
        inHour   = 8'h1A;
        runPeriod("bad_hour1A");
        load = 1'b0;
        for (int i = 0; i < 28; i++) runPeriod("to_102030");

        // Asynchronous reset between edges mid-count at 10:20:30.
        applyStimulus(8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, "pre_reset");
        #2 RST = 1'b1;
        #1;
        pushExp(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "reset_midcount");
        checkOutput();

        // Release with mode=1: first edge converts 00 to 12 AM.
        mode = 1'b1;
        #2 RST = 1'b0;
        applyStimulus(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "release_12h");
        applyStimulus(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "release_idle1");
        applyStimulus(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "release_idle2");
        applyStimulus(8'h12, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, "release_tick");
        setModel(12, 0, 1, 1'b0, 1'b1);
        runPeriod("after_release");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
